// File: rtl/divide_arbiter.sv
// Round-robin shared divider: NUM_REQ requesters share one reciprocal LUT and one multiplier.
// Three-stage pipeline (capture, reciprocal lookup, multiply) with a global stall on output backpressure.
module divide_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_W   = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*NUM_W-1:0] req_num,
    input  logic [NUM_REQ*10-1:0]    req_den,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [NUM_W-1:0]         resp_quot,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_div_zero,
    output logic                     busy
);
    localparam int PROD_W = NUM_W + 16;

    // Reciprocal table in 1.15: floor(2^15 / den); entry 0 is unused and reads as zero.
    logic [15:0] inv_rom [1024];
    for (genvar g = 0; g < 1024; g++) begin : g_rom
        assign inv_rom[g] = (g == 0) ? 16'd0 : 16'(32768 / ((g == 0) ? 1 : g));
    end

    function automatic logic [NUM_W-1:0] scale_quot(input logic [PROD_W-1:0] prod,
                                                    input logic              div_zero);
        if (div_zero) return '1;
        return prod[NUM_W+14:15];
    endfunction

    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic              advance;
    logic              handshake;

    logic              vld_p0, vld_p1, vld_p2;
    logic [ID_W-1:0]   id_p0, id_p1;
    logic [NUM_W-1:0]  num_p0, num_p1;
    logic [9:0]        den_p0;
    logic [15:0]       inv_p1;
    logic              dz_p1;
    logic [PROD_W-1:0] prod_p1;

    assign advance    = !vld_p2 || resp_ready;
    assign handshake  = advance && found;
    assign resp_valid = vld_p2;
    assign busy       = vld_p0 || vld_p1 || vld_p2;
    assign prod_p1    = PROD_W'(num_p1) * PROD_W'(inv_p1);

    always_comb begin
        grant     = '0;
        idx       = '0;
        found     = 1'b0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        if (advance && found) req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            resp_quot     <= '0;
            resp_id       <= '0;
            resp_div_zero <= 1'b0;
        end else if (advance) begin
            vld_p0 <= handshake;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (handshake) last_grant <= grant;
            // p1 -> p2: product scaled back to NUM_W, divide-by-zero saturates
            resp_quot     <= scale_quot(prod_p1, dz_p1);
            resp_id       <= id_p1;
            resp_div_zero <= dz_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            // grant -> p0: capture the winning requester's operands
            id_p0  <= grant;
            num_p0 <= req_num[int'(grant)*NUM_W +: NUM_W];
            den_p0 <= req_den[int'(grant)*10 +: 10];
            // p0 -> p1: reciprocal lookup
            id_p1  <= id_p0;
            num_p1 <= num_p0;
            inv_p1 <= inv_rom[den_p0];
            dz_p1  <= (den_p0 == 10'd0);
        end
    end
endmodule
